traffic_light_monitor: RTL

//  Passive checker on the consumer side of the traffic_light light bus. It samples the

---
 rtl/traffic_light_monitor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive safety and sequencing checker for the traffic light bus
module traffic_light_monitor #(
   parameter int MIN_YELLOW  = 2,
   parameter int MAX_YELLOW  = 8,
   parameter int MAX_ALL_RED = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       north_light,
   input  logic [2:0]       south_light,
   input  logic [2:0]       east_light,
   input  logic [2:0]       west_light,
   input  logic             fault_clr,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic             fault_axis,
   output logic [CNT_W-1:0] fault_count,
   output logic [CNT_W-1:0] phase_count
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   localparam int YC_W = $clog2(MAX_YELLOW + 2);
   localparam int AC_W = $clog2(MAX_ALL_RED + 2);
   localparam logic [YC_W-1:0] Y_LIMIT = YC_W'(MAX_YELLOW + 1);
   localparam logic [AC_W-1:0] A_LIMIT = AC_W'(MAX_ALL_RED + 1);
   localparam logic [YC_W-1:0] Y_MIN   = YC_W'(MIN_YELLOW);

   function automatic logic is_legal(input logic [2:0] c);
      return (c == RED) || (c == YEL) || (c == GRN);
   endfunction

   // Index 0 is the NS axis (north/south), index 1 is the EW axis (east/west).
   logic [2:0] light_a [2];
   logic [2:0] light_b [2];

   assign light_a[0] = north_light;
   assign light_b[0] = south_light;
   assign light_a[1] = east_light;
   assign light_b[1] = west_light;

   logic [2:0]      prev_state [2];
   logic [1:0]      prev_valid;
   logic [YC_W-1:0] ycnt [2];
   logic [AC_W-1:0] acnt;

   logic [1:0]      ax_valid;
   logic [1:0]      ax_mismatch;
   logic [1:0]      ax_non_red;
   logic [1:0]      ax_bad_trans;
   logic [1:0]      ax_short_y;
   logic [1:0]      ax_long_y;
   logic [YC_W-1:0] ycnt_next [2];
   logic [AC_W-1:0] acnt_next;
   logic            all_red;
   logic            any_illegal;
   logic            conflict;
   logic            long_red;
   logic            ns_enter_green;

   always_comb begin
      ax_valid     = '0;
      ax_mismatch  = '0;
      ax_non_red   = '0;
      ax_bad_trans = '0;
      ax_short_y   = '0;
      ax_long_y    = '0;
      ycnt_next[0] = '0;
      ycnt_next[1] = '0;
      for (int i = 0; i < 2; i++) begin
         ax_valid[i]    = (light_a[i] == light_b[i]) && is_legal(light_a[i]);
         ax_mismatch[i] = is_legal(light_a[i]) && is_legal(light_b[i]) &&
                          (light_a[i] != light_b[i]);
         ax_non_red[i]  = (light_a[i] != RED) || (light_b[i] != RED);
         ax_bad_trans[i] = ax_valid[i] && prev_valid[i] &&
                           (((prev_state[i] == GRN) && (light_a[i] == RED)) ||
                            ((prev_state[i] == RED) && (light_a[i] == YEL)) ||
                            ((prev_state[i] == YEL) && (light_a[i] == GRN)));
         ax_short_y[i]  = ax_valid[i] && prev_valid[i] && (prev_state[i] == YEL) &&
                          (light_a[i] == RED) && (ycnt[i] < Y_MIN);
         // Counter saturates one past the limit so the overrun is flagged once per episode.
         if (ax_valid[i] && (light_a[i] == YEL))
            ycnt_next[i] = (ycnt[i] == Y_LIMIT) ? ycnt[i] : ycnt[i] + 1'b1;
         else
            ycnt_next[i] = '0;
         ax_long_y[i]   = (ycnt[i] != Y_LIMIT) && (ycnt_next[i] == Y_LIMIT);
      end

      all_red   = ax_valid[0] && ax_valid[1] && (north_light == RED) && (east_light == RED);
      acnt_next = all_red ? ((acnt == A_LIMIT) ? acnt : acnt + 1'b1) : '0;
      long_red  = (acnt != A_LIMIT) && (acnt_next == A_LIMIT);

      any_illegal = !is_legal(north_light) || !is_legal(south_light) ||
                    !is_legal(east_light)  || !is_legal(west_light);
      conflict    = ax_non_red[0] && ax_non_red[1];

      ns_enter_green = ax_valid[0] && prev_valid[0] && (prev_state[0] == RED) &&
                       (north_light == GRN);
   end

   logic [2:0] viol_code;
   logic       viol_axis;
   logic       any_viol;

   // Lowest code wins; within a code the NS axis is tested first.
   always_comb begin
      viol_code = 3'd0;
      viol_axis = 1'b0;
      if (any_illegal) begin
         viol_code = 3'd1;
      end else if (ax_mismatch[0]) begin
         viol_code = 3'd2;
      end else if (ax_mismatch[1]) begin
         viol_code = 3'd2;
         viol_axis = 1'b1;
      end else if (conflict) begin
         viol_code = 3'd3;
      end else if (ax_bad_trans[0]) begin
         viol_code = 3'd4;
      end else if (ax_bad_trans[1]) begin
         viol_code = 3'd4;
         viol_axis = 1'b1;
      end else if (ax_short_y[0]) begin
         viol_code = 3'd5;
      end else if (ax_short_y[1]) begin
         viol_code = 3'd5;
         viol_axis = 1'b1;
      end else if (ax_long_y[0]) begin
         viol_code = 3'd6;
      end else if (ax_long_y[1]) begin
         viol_code = 3'd6;
         viol_axis = 1'b1;
      end else if (long_red) begin
         viol_code = 3'd7;
      end
      any_viol = (viol_code != 3'd0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_state[0] <= '0;
         prev_state[1] <= '0;
         prev_valid    <= '0;
         ycnt[0]       <= '0;
         ycnt[1]       <= '0;
         acnt          <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (ax_valid[i]) begin
               prev_state[i] <= light_a[i];
               prev_valid[i] <= 1'b1;
            end
            ycnt[i] <= ycnt_next[i];
         end
         acnt <= acnt_next;
      end
   end

   // A violation in the same sample as a clear re-latches instead of clearing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fault       <= 1'b0;
         fault_code  <= 3'd0;
         fault_axis  <= 1'b0;
         fault_count <= '0;
         phase_count <= '0;
      end else begin
         if (any_viol && (!fault || fault_clr)) begin
            fault      <= 1'b1;
            fault_code <= viol_code;
            fault_axis <= viol_axis;
         end else if (fault_clr) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
            fault_axis <= 1'b0;
         end
         if (any_viol && (fault_count != '1))
            fault_count <= fault_count + 1'b1;
         if (ns_enter_green)
            phase_count <= phase_count + 1'b1;
      end
   end

endmodule
